// File: rtl/reset_seq_pkg.sv
// Shared definitions for the board reset sequencer: FSM state encoding,
// reset-cause codes and counter widths.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    S_PLLRST   = 3'd0,
    S_LOCKWAIT = 3'd1,
    S_PERIPH   = 3'd2,
    S_RUN      = 3'd3,
    S_HOLD     = 3'd4
  } state_t;

  localparam logic [1:0] CAUSE_POR = 2'd0;
  localparam logic [1:0] CAUSE_KEY = 2'd1;
  localparam logic [1:0] CAUSE_SW  = 2'd2;

  localparam int CNT_W    = 16;
  localparam int DB_CNT_W = 20;

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioning: two-flop synchronizer followed by a level
// debouncer that accepts a new level only after it has been stable long enough.
module key_debounce
  import reset_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rstn,
  input  logic key_in_n,
  output logic key_db
);

  localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                sync1_reg;
  logic                sync2_reg;
  logic [DB_CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
    end else begin
      sync1_reg <= key_in_n;
      sync2_reg <= sync1_reg;
    end
  end

  // Counter only runs while the synchronized level disagrees with key_db;
  // it stops at its terminal value, where the new level is accepted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_reg <= '0;
      key_db  <= 1'b1;
    end else if (sync2_reg == key_db) begin
      cnt_reg <= '0;
    end else if (cnt_reg >= DB_LAST) begin
      cnt_reg <= '0;
      key_db  <= sync2_reg;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Board reset sequencer: PLL reset, lock wait, peripheral release, then CPU
// release; restarted by a debounced reset key or a software request.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES   = 16,
  parameter int LOCK_WAIT_CYCLES = 5000,
  parameter int STAGE_GAP        = 16,
  parameter int DEBOUNCE_CYCLES  = 500000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       key_rst_n,
  input  logic       sw_rst_req,
  output logic       pll_reset,
  output logic       periph_rstn,
  output logic       cpu_rstn,
  output logic [1:0] rst_cause,
  output logic       busy
);

  localparam logic [CNT_W-1:0] PLL_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);

  logic             key_db;
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       cause_reg, cause_next;
  logic             pll_next, periph_next, cpu_next, busy_next;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk     (clk),
    .rstn    (rstn),
    .key_in_n(key_rst_n),
    .key_db  (key_db)
  );

  // Outputs are decoded from state_next and registered, so they change on
  // the same edge as the state and never see an input combinationally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= S_PLLRST;
      cnt_reg     <= '0;
      cause_reg   <= CAUSE_POR;
      pll_reset   <= 1'b1;
      periph_rstn <= 1'b0;
      cpu_rstn    <= 1'b0;
      busy        <= 1'b1;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      cause_reg   <= cause_next;
      pll_reset   <= pll_next;
      periph_rstn <= periph_next;
      cpu_rstn    <= cpu_next;
      busy        <= busy_next;
    end
  end

  assign rst_cause = cause_reg;

  always_comb begin
    state_next = state_reg;
    cause_next = cause_reg;
    if (!key_db) begin
      // The key overrides everything, including a same-cycle software request.
      state_next = S_HOLD;
      cause_next = CAUSE_KEY;
    end else begin
      case (state_reg)
        S_PLLRST:   if (cnt_reg >= PLL_LAST)  state_next = S_LOCKWAIT;
        S_LOCKWAIT: if (cnt_reg >= LOCK_LAST) state_next = S_PERIPH;
        S_PERIPH:   if (cnt_reg >= GAP_LAST)  state_next = S_RUN;
        S_RUN: begin
          if (sw_rst_req) begin
            state_next = S_PLLRST;
            cause_next = CAUSE_SW;
          end
        end
        S_HOLD: begin
          state_next = S_PLLRST;
          cause_next = CAUSE_KEY;
        end
        default: state_next = S_PLLRST;
      endcase
    end

    if (state_next != state_reg) begin
      cnt_next = '0;
    end else if (cnt_reg == {CNT_W{1'b1}}) begin
      cnt_next = cnt_reg;
    end else begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_comb begin
    pll_next    = 1'b0;
    periph_next = 1'b0;
    cpu_next    = 1'b0;
    busy_next   = 1'b1;
    case (state_next)
      S_PLLRST:   pll_next = 1'b1;
      S_LOCKWAIT: pll_next = 1'b0;
      S_PERIPH:   periph_next = 1'b1;
      S_RUN: begin
        periph_next = 1'b1;
        cpu_next    = 1'b1;
        busy_next   = 1'b0;
      end
      S_HOLD:     pll_next = 1'b1;
      default:    pll_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: expected output snapshots
// {pll_reset, periph_rstn, cpu_rstn, busy, rst_cause} are queued and popped per cycle.
module tb_reset_sequencer;

  localparam int P = 4;
  localparam int L = 10;
  localparam int S = 3;
  localparam int D = 8;
  localparam int SEQ_LEN = P + L + S + 3;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       key_rst_n = 1'b1;
  logic       sw_rst_req = 1'b0;
  logic       pll_reset;
  logic       periph_rstn;
  logic       cpu_rstn;
  logic [1:0] rst_cause;
  logic       busy;

  int         checks = 0;
  int         errors = 0;
  logic [5:0] sb_q[$];
  logic [1:0] model_cause = 2'd0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .PLL_RST_CYCLES  (P),
    .LOCK_WAIT_CYCLES(L),
    .STAGE_GAP       (S),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .key_rst_n  (key_rst_n),
    .sw_rst_req (sw_rst_req),
    .pll_reset  (pll_reset),
    .periph_rstn(periph_rstn),
    .cpu_rstn   (cpu_rstn),
    .rst_cause  (rst_cause),
    .busy       (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Snapshot e is the state right after the e-th edge of a sequence (e=0: sequence entered).
  task automatic push_seq(input logic [1:0] cause);
    model_cause = cause;
    for (int e = 0; e < SEQ_LEN; e++) begin
      if (e < P)              sb_q.push_back({4'b1001, cause});
      else if (e < P + L)     sb_q.push_back({4'b0001, cause});
      else if (e < P + L + S) sb_q.push_back({4'b0101, cause});
      else                    sb_q.push_back({4'b0110, cause});
    end
  endtask

  task automatic push_const(input logic [3:0] outs, input logic [1:0] cause, input int n);
    model_cause = cause;
    for (int k = 0; k < n; k++) sb_q.push_back({outs, cause});
  endtask

  task automatic test_reset();
    logic [5:0] exp_v, act_v;
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_v = {4'b1001, 2'd0};
      act_v = {pll_reset, periph_rstn, cpu_rstn, busy, rst_cause};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL reset_hold[%0d] got %b expected %b", i, act_v, exp_v);
      end
    end
    rstn = 1'b1;
    push_seq(2'd0);
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (i != 0) step();
      exp_v = sb_q.pop_front();
      act_v = {pll_reset, periph_rstn, cpu_rstn, busy, rst_cause};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL power_on[%0d] got %b expected %b", i, act_v, exp_v);
      end
    end
    $display("test_reset done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_bounce();
    logic [5:0] exp_v, act_v;
    push_const(4'b0110, model_cause, 42);
    for (int i = 0; i < 42; i++) begin
      key_rst_n = (i < 30 && (i % 10) < 5) ? 1'b0 : 1'b1;
      step();
      exp_v = sb_q.pop_front();
      act_v = {pll_reset, periph_rstn, cpu_rstn, busy, rst_cause};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL bounce[%0d] got %b expected %b", i, act_v, exp_v);
      end
    end
    key_rst_n = 1'b1;
    $display("test_bounce done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_key_reset();
    logic [5:0] exp_v, act_v;
    // 2 sync + D debounce edges before key_db falls, one more to enter S_HOLD.
    push_const(4'b0110, model_cause, 2 + D);
    push_const(4'b1001, 2'd1, 30);
    push_seq(2'd1);
    key_rst_n = 1'b0;
    for (int i = 1; i <= 40 + SEQ_LEN; i++) begin
      step();
      exp_v = sb_q.pop_front();
      act_v = {pll_reset, periph_rstn, cpu_rstn, busy, rst_cause};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL key_reset[%0d] got %b expected %b", i, act_v, exp_v);
      end
      if (i == 30) key_rst_n = 1'b1;
    end
    $display("test_key_reset done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_sw_reset();
    logic [5:0] exp_v, act_v;
    // Second pulse lands in S_LOCKWAIT and must leave the timing untouched.
    push_seq(2'd2);
    for (int i = 0; i < SEQ_LEN; i++) begin
      sw_rst_req = (i == 0 || i == 6) ? 1'b1 : 1'b0;
      step();
      exp_v = sb_q.pop_front();
      act_v = {pll_reset, periph_rstn, cpu_rstn, busy, rst_cause};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL sw_reset[%0d] got %b expected %b", i, act_v, exp_v);
      end
    end
    sw_rst_req = 1'b0;
    $display("test_sw_reset done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_simultaneous();
    logic [5:0] exp_v, act_v;
    push_const(4'b0110, model_cause, 10);
    push_const(4'b1001, 2'd1, 12);
    push_seq(2'd1);
    for (int i = 1; i <= 22 + SEQ_LEN; i++) begin
      key_rst_n  = (i <= 12) ? 1'b0 : 1'b1;
      sw_rst_req = (i == 11) ? 1'b1 : 1'b0;
      step();
      exp_v = sb_q.pop_front();
      act_v = {pll_reset, periph_rstn, cpu_rstn, busy, rst_cause};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL simultaneous[%0d] got %b expected %b", i, act_v, exp_v);
      end
    end
    sw_rst_req = 1'b0;
    key_rst_n  = 1'b1;
    $display("test_simultaneous done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_mid_reset();
    logic [5:0] exp_v, act_v;
    push_seq(2'd2);
    for (int i = 0; i < P + L + 2; i++) begin
      sw_rst_req = (i == 0) ? 1'b1 : 1'b0;
      step();
      exp_v = sb_q.pop_front();
      act_v = {pll_reset, periph_rstn, cpu_rstn, busy, rst_cause};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL mid_pre[%0d] got %b expected %b", i, act_v, exp_v);
      end
    end
    sw_rst_req = 1'b0;
    sb_q.delete();
    // Assert between clock edges: outputs must change without waiting for clk.
    #2 rstn = 1'b0;
    #1;
    exp_v = {4'b1001, 2'd0};
    act_v = {pll_reset, periph_rstn, cpu_rstn, busy, rst_cause};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL mid_async got %b expected %b", act_v, exp_v);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      act_v = {pll_reset, periph_rstn, cpu_rstn, busy, rst_cause};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL mid_hold[%0d] got %b expected %b", i, act_v, exp_v);
      end
    end
    rstn = 1'b1;
    push_seq(2'd0);
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (i != 0) step();
      exp_v = sb_q.pop_front();
      act_v = {pll_reset, periph_rstn, cpu_rstn, busy, rst_cause};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL mid_restart[%0d] got %b expected %b", i, act_v, exp_v);
      end
    end
    $display("test_mid_reset done checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_key_reset();
    test_sw_reset();
    test_simultaneous();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter PLL_RST_CYCLES, default 16: cycles pll_reset is held high per sequence; legal range 1..65535.
REQ-002 Parameter LOCK_WAIT_CYCLES, default 5000: cycles from pll_reset fall to periph_rstn rise (100 us at 50 MHz); legal range 1..65535.
REQ-003 Parameter STAGE_GAP, default 16: cycles from periph_rstn rise to cpu_rstn rise; legal range 1..65535.
REQ-004 Parameter DEBOUNCE_CYCLES, default 500000: stable cycles required to accept a key level change (10 ms at 50 MHz); legal range 1..2^20-1.
REQ-005 clk  input  1  50 MHz board reference clock, same net as the system PLL refclk; the only clock.
REQ-006 rstn  input  1  asynchronous, active-low power-on reset.
REQ-007 key_rst_n  input  1  raw push-button reset, active-low, asynchronous to clk, bouncing.
REQ-008 sw_rst_req  input  1  single-cycle software reset request, synchronous to clk.
REQ-009 pll_reset  output  1  active-high reset to the system PLL.
REQ-010 periph_rstn  output  1  active-low reset for the peripheral domain.
REQ-011 cpu_rstn  output  1  active-low reset for the CPU domain.
REQ-012 rst_cause  output  2  cause of the last sequence: 0 power-on, 1 key, 2 software; 3 is never driven.
REQ-013 busy  output  1  high in every state except S_RUN.

Function
REQ-014 All outputs are registered; there is no combinational path from any input to any output.
REQ-015 key_rst_n passes through a 2-flop synchronizer, then the debouncer.
REQ-016 Debouncer: key_db (reset value 1) takes the synchronized level after it has differed from key_db for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle clears the counter.
REQ-017 FSM states: S_PLLRST, S_LOCKWAIT, S_PERIPH, S_RUN, S_HOLD; one shared cycle counter is cleared on every state change.
REQ-018 S_PLLRST: pll_reset=1, periph_rstn=0, cpu_rstn=0. After PLL_RST_CYCLES cycles in this state, go to S_LOCKWAIT.
REQ-019 S_LOCKWAIT: pll_reset=0, periph_rstn=0, cpu_rstn=0. After LOCK_WAIT_CYCLES cycles in this state, go to S_PERIPH.
REQ-020 S_PERIPH: pll_reset=0, periph_rstn=1, cpu_rstn=0. After STAGE_GAP cycles in this state, go to S_RUN.
REQ-021 S_RUN: pll_reset=0, periph_rstn=1, cpu_rstn=1.
REQ-022 S_HOLD: pll_reset=1, periph_rstn=0, cpu_rstn=0. Stay while key_db=0; when key_db=1, go to S_PLLRST with rst_cause set to 1.
REQ-023 key_db=0 in any state forces S_HOLD on the next cycle, restarting any sequence in progress.
REQ-024 sw_rst_req=1 in S_RUN (with key_db=1) goes to S_PLLRST and sets rst_cause to 2.
REQ-025 sw_rst_req outside S_RUN is ignored and not remembered.
REQ-026 If key_db=0 and sw_rst_req=1 in the same cycle, the key wins: next state S_HOLD, rst_cause ends at 1.
REQ-027 Timing from the first edge after rstn release:
- pll_reset stays high for exactly PLL_RST_CYCLES cycles;
- periph_rstn rises exactly LOCK_WAIT_CYCLES cycles after pll_reset falls;
- cpu_rstn rises exactly STAGE_GAP cycles after periph_rstn rises.
REQ-028 The cycle counter is 16 bits wide; the debounce counter is 20 bits wide. Neither wraps: each saturates at its terminal value.

Reset
REQ-029 rstn=0 asynchronously forces: state S_PLLRST, counters 0, synchronizer flops 1, key_db=1, pll_reset=1, periph_rstn=0, cpu_rstn=0, rst_cause=0, busy=1.
REQ-030 rstn assertion mid-sequence aborts the sequence immediately; on release the full sequence restarts with rst_cause=0.

Structure
REQ-031 Shared package reset_seq_pkg holds the state encoding and the cause constants CAUSE_POR=0, CAUSE_KEY=1, CAUSE_SW=2.
REQ-032 The synchronizer and debouncer form one sub-module, key_debounce (ports clk, rstn, key_in_n, key_db), parameterised by DEBOUNCE_CYCLES.

Verification (bench parameters: PLL_RST_CYCLES=4, LOCK_WAIT_CYCLES=10, STAGE_GAP=3, DEBOUNCE_CYCLES=8)
REQ-033 Power-on: release rstn -> pll_reset high for 4 cycles, periph_rstn rises 10 cycles later, cpu_rstn rises 3 cycles after that, busy falls with cpu_rstn, rst_cause=0.
REQ-034 Bounce: in S_RUN, toggle key_rst_n low for 5 cycles, three times -> no state change, all resets stay released.
REQ-035 Key reset: in S_RUN, hold key_rst_n low for 30 cycles then release -> S_HOLD with pll_reset=1 and cpu_rstn=0 while held; after release plus debounce, full sequence reruns with rst_cause=1.
REQ-036 Software reset: pulse sw_rst_req in S_RUN -> pll_reset=1 on the next cycle, full sequence reruns, rst_cause=2. Pulse sw_rst_req in S_LOCKWAIT -> ignored, sequence timing unchanged.
REQ-037 Simultaneous events: key_db falls in the same cycle as sw_rst_req -> S_HOLD, rst_cause=1.
REQ-038 Mid-sequence reset: assert rstn during S_PERIPH -> all outputs take reset values asynchronously; after release, timing matches REQ-033 exactly.
